dlx_fwd_ctrl: RTL and testbench

Forwarding and hazard control for the 5-stage DLX integer pipeline. It drives the 2-bit selects of the two EX-stage 3-input operand muxes: 00 selects the register-file value, 01 the EX/MEM ALU result, 10 the MEM/WB write-back value. It tracks destination registers of in-flight instructions in internal EX/MEM/WB shadow registers. It stalls ID on load-use hazards and counts stall cycles.

---
 rtl/dlx_fwd_ctrl.sv | 128 ++++++++++++
 tb/tb_dlx_fwd_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dlx_fwd_ctrl.sv
// Operand-forwarding select and load-use stall control for the 5-stage DLX pipeline.
// Shadows EX/MEM/WB destination info internally and counts stall cycles (saturating).
module dlx_fwd_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wr_en,
   input  logic              id_is_load,
   output logic [1:0]        fwd_sel_a,
   output logic [1:0]        fwd_sel_b,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0] SelRf  = 2'b00;
   localparam logic [1:0] SelMem = 2'b01;
   localparam logic [1:0] SelWb  = 2'b10;

   logic              ex_valid_q, ex_rs1_used_q, ex_rs2_used_q, ex_wr_q, ex_load_q;
   logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
   logic              mem_valid_q, mem_wr_q, mem_load_q;
   logic [REG_AW-1:0] mem_rd_q;
   logic              wb_valid_q, wb_wr_q;
   logic [REG_AW-1:0] wb_rd_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic              ex_take;

   // R0 is hard-wired zero, so a write to it never produces a forwardable value.
   function automatic logic stage_writes(input logic              valid,
                                         input logic              wr,
                                         input logic [REG_AW-1:0] rd,
                                         input logic [REG_AW-1:0] r);
      return valid & wr & (rd == r) & (r != '0);
   endfunction

   function automatic logic [1:0] pick_sel(input logic              used,
                                           input logic [REG_AW-1:0] src);
      logic [1:0] sel;
      sel = SelRf;
      if (ex_valid_q && used) begin
         if (stage_writes(mem_valid_q, mem_wr_q, mem_rd_q, src) && !mem_load_q) begin
            sel = SelMem;
         end else if (stage_writes(wb_valid_q, wb_wr_q, wb_rd_q, src)) begin
            sel = SelWb;
         end
      end
      return sel;
   endfunction

   always_comb begin
      fwd_sel_a = pick_sel(ex_rs1_used_q, ex_rs1_q);
      fwd_sel_b = pick_sel(ex_rs2_used_q, ex_rs2_q);
   end

   always_comb begin
      stall = 1'b0;
      if (id_valid && !flush && ex_load_q) begin
         stall = (id_rs1_used && stage_writes(ex_valid_q, ex_wr_q, ex_rd_q, id_rs1)) ||
                 (id_rs2_used && stage_writes(ex_valid_q, ex_wr_q, ex_rd_q, id_rs2));
      end
   end

   assign ex_take   = id_valid & ~stall & ~flush;
   assign stall_cnt = stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q    <= 1'b0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rs1_used_q <= 1'b0;
         ex_rs2_used_q <= 1'b0;
         ex_rd_q       <= '0;
         ex_wr_q       <= 1'b0;
         ex_load_q     <= 1'b0;
         mem_valid_q   <= 1'b0;
         mem_rd_q      <= '0;
         mem_wr_q      <= 1'b0;
         mem_load_q    <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_rd_q       <= '0;
         wb_wr_q       <= 1'b0;
         stall_cnt_q   <= '0;
      end else if (en) begin
         wb_valid_q  <= mem_valid_q;
         wb_rd_q     <= mem_rd_q;
         wb_wr_q     <= mem_wr_q;
         mem_valid_q <= ex_valid_q;
         mem_rd_q    <= ex_rd_q;
         mem_wr_q    <= ex_wr_q;
         mem_load_q  <= ex_load_q;
         if (ex_take) begin
            ex_valid_q    <= 1'b1;
            ex_rs1_q      <= id_rs1;
            ex_rs2_q      <= id_rs2;
            ex_rs1_used_q <= id_rs1_used;
            ex_rs2_used_q <= id_rs2_used;
            ex_rd_q       <= id_rd;
            ex_wr_q       <= id_wr_en;
            ex_load_q     <= id_is_load;
         end else begin
            ex_valid_q    <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
            ex_rd_q       <= '0;
            ex_wr_q       <= 1'b0;
            ex_load_q     <= 1'b0;
         end
         if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_dlx_fwd_ctrl.sv
// Directed bench for dlx_fwd_ctrl: forwarding selects, load-use stall, flush, freeze,
// counter saturation (second instance with a 4-bit counter) and async reset.
module tb_dlx_fwd_ctrl;

   logic       clk, rst_n, en, flush;
   logic       id_valid, id_rs1_used, id_rs2_used, id_wr_en, id_is_load;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [1:0] sel_a, sel_b, sel_a4, sel_b4;
   logic       stall, stall4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   int n_checks = 0;
   int n_err    = 0;

   dlx_fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
      .id_is_load(id_is_load), .fwd_sel_a(sel_a), .fwd_sel_b(sel_b),
      .stall(stall), .stall_cnt(cnt)
   );

   dlx_fwd_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
      .id_is_load(id_is_load), .fwd_sel_a(sel_a4), .fwd_sel_b(sel_b4),
      .stall(stall4), .stall_cnt(cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
      id_rd = rd; id_wr_en = wr; id_is_load = ld;
      #1;
   endtask

   task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      set_id(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0);
   endtask

   task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
      set_id(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1);
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; flush = 1'b0;
      nop();
      #2;
      chk("rst_sel_a", sel_a, 2'b00);
      chk("rst_sel_b", sel_b, 2'b00);
      chk("rst_stall", stall, 1'b0);
      chk("rst_cnt", cnt, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD R3,R1,R2 ; SUB R4,R3,R5
      step(); alu(5'd3, 5'd1, 5'd2);
      chk("t1_stall_add", stall, 1'b0);
      step(); alu(5'd4, 5'd3, 5'd5);
      chk("t1_stall_sub", stall, 1'b0);
      step(); nop();
      chk("t1_sel_a", sel_a, 2'b01);
      chk("t1_sel_b", sel_b, 2'b00);
      chk("t1_stall_ex", stall, 1'b0);

      // ADD R3 ; NOP ; OR R6,R7,R3
      alu(5'd3, 5'd1, 5'd2);
      step(); nop();
      step(); alu(5'd6, 5'd7, 5'd3);
      step(); nop();
      chk("t2_sel_a", sel_a, 2'b00);
      chk("t2_sel_b", sel_b, 2'b10);

      // ADD R3 ; ADD R3 ; AND R8,R3,R3
      alu(5'd3, 5'd1, 5'd2);
      step(); alu(5'd3, 5'd4, 5'd5);
      step(); alu(5'd8, 5'd3, 5'd3);
      step(); nop();
      chk("t3_sel_a", sel_a, 2'b01);
      chk("t3_sel_b", sel_b, 2'b01);

      // LW R5,0(R1) ; ADD R6,R5,R2
      lw(5'd5, 5'd1);
      step(); alu(5'd6, 5'd5, 5'd2);
      chk("t4_stall_hit", stall, 1'b1);
      chk("t4_cnt_before", cnt, 16'd0);
      step();
      chk("t4_stall_drop", stall, 1'b0);
      chk("t4_cnt_after", cnt, 16'd1);
      step(); nop();
      chk("t4_sel_a", sel_a, 2'b10);
      chk("t4_sel_b", sel_b, 2'b00);

      // LW R0 ; ADD R9,R0,R0
      lw(5'd0, 5'd1);
      step(); alu(5'd9, 5'd0, 5'd0);
      chk("t4_r0_stall", stall, 1'b0);
      step(); nop();
      chk("t4_r0_sel_a", sel_a, 2'b00);
      chk("t4_r0_sel_b", sel_b, 2'b00);
      chk("t4_r0_cnt", cnt, 16'd1);

      // Flush in the hazard cycle squashes the consumer
      lw(5'd5, 5'd1);
      step(); alu(5'd6, 5'd5, 5'd2); flush = 1'b1; #1;
      chk("t5_flush_stall", stall, 1'b0);
      step(); flush = 1'b0; alu(5'd11, 5'd6, 5'd6);
      chk("t5_flush_cnt", cnt, 16'd1);
      step(); nop();
      chk("t5_flush_sel_a", sel_a, 2'b00);
      chk("t5_flush_sel_b", sel_b, 2'b00);

      // en=0 during a hazard freezes everything
      lw(5'd5, 5'd1);
      step(); alu(5'd6, 5'd5, 5'd2);
      chk("t5_en_stall0", stall, 1'b1);
      en = 1'b0;
      step(); step();
      chk("t5_en_stall_held", stall, 1'b1);
      chk("t5_en_cnt_frozen", cnt, 16'd1);
      en = 1'b1;
      step();
      chk("t5_en_cnt_inc", cnt, 16'd2);
      chk("t5_en_stall_drop", stall, 1'b0);
      step(); nop();
      chk("t5_en_sel_a", sel_a, 2'b10);

      // 20 more load-use pairs
      for (int i = 0; i < 20; i++) begin
         lw(5'd5, 5'd1);
         step(); alu(5'd6, 5'd5, 5'd2);
         step();
         step();
      end
      chk("t6_cnt16", cnt, 16'd22);
      chk("t6_cnt4_sat", cnt4, 4'd15);

      // Reset mid-stall with a live MEM forward (LW R5,0(R6) behind ADD R6)
      lw(5'd5, 5'd6);
      step(); alu(5'd7, 5'd5, 5'd5);
      chk("t6_pre_stall", stall, 1'b1);
      chk("t6_pre_sel_a", sel_a, 2'b01);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_stall", stall, 1'b0);
      chk("t6_rst_stall4", stall4, 1'b0);
      chk("t6_rst_sel_a", sel_a, 2'b00);
      chk("t6_rst_sel_b", sel_b, 2'b00);
      chk("t6_rst_cnt", cnt, 16'd0);
      chk("t6_rst_cnt4", cnt4, 4'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
